// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding, opcodes, funct7 values and the
// RV32I decode helper used by the issue stage.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic       legal;
        logic       rtype;
        logic [2:0] ctrl;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t       d;
        logic [6:0] f7;
        logic [2:0] f3;
        d  = '0;
        f7 = ins[31:25];
        f3 = ins[14:12];
        case (ins[6:0])
            OPC_OP: begin
                d.rtype = 1'b1;
                d.legal = 1'b1;
                if (f7 == F7_ALT && f3 == 3'b000) begin
                    d.ctrl = ALU_SUB;
                end else if (f7 != F7_BASE) begin
                    d.legal = 1'b0;
                end else begin
                    case (f3)
                        3'b000:  d.ctrl = ALU_ADD;
                        3'b111:  d.ctrl = ALU_AND;
                        3'b110:  d.ctrl = ALU_OR;
                        3'b100:  d.ctrl = ALU_XOR;
                        3'b001:  d.ctrl = ALU_SLL;
                        3'b101:  d.ctrl = ALU_SRL;
                        3'b010:  d.ctrl = ALU_SLT;
                        default: d.legal = 1'b0;
                    endcase
                end
            end
            OPC_OPIMM: begin
                d.legal = 1'b1;
                case (f3)
                    3'b000: d.ctrl = ALU_ADD;
                    3'b111: d.ctrl = ALU_AND;
                    3'b110: d.ctrl = ALU_OR;
                    3'b100: d.ctrl = ALU_XOR;
                    3'b010: d.ctrl = ALU_SLT;
                    3'b001: begin
                        d.ctrl  = ALU_SLL;
                        d.legal = (f7 == F7_BASE);
                    end
                    // SRAI shares funct3 101 and is rejected through funct7.
                    3'b101: begin
                        d.ctrl  = ALU_SRL;
                        d.legal = (f7 == F7_BASE);
                    end
                    default: d.legal = 1'b0;
                endcase
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, x0 hardwired to zero, synchronous clear on rst.
module regfile import alu_pkg::*; (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] mem [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
        end else if (we && wa != 5'd0) begin
            mem[wa] <= wd;
        end
    end

    // Reads see the pre-write value; any bypass lives in the caller.
    assign rd1 = (ra1 == 5'd0) ? '0 : mem[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : mem[ra2];

endmodule

// File: rtl/alu_issue.sv
// RV32I decode/operand-issue stage feeding the ALU and writing back its result.
// Build option ALU_ISSUE_FWD_EN: forward Result on RAW hazards instead of stalling.
module alu_issue import alu_pkg::*; (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [2:0]      ALUControl,
    output logic [4:0]      Rd,
    output logic            ex_valid,
    input  logic            ex_ready,
    input  logic [XLEN-1:0] Result,
    output logic            illegal
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // valid never depends on ready; once ex_valid is raised, A/B/ALUControl/Rd
    // hold until ex_ready is seen with it.

    dec_t            dec;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rf_a;
    logic [XLEN-1:0] rf_b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            retire;
    logic            wb_en;
    logic            haz_a;
    logic            haz_b;
    logic            stall_haz;
    logic            accept;

    assign dec = decode(instr);
    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign imm = {{(XLEN-12){instr[31]}}, instr[31:20]};

    assign retire = ex_valid && ex_ready;
    assign wb_en  = retire && (Rd != 5'd0);

    assign haz_a = instr_valid && dec.legal && wb_en && (rs1 == Rd);
    assign haz_b = instr_valid && dec.legal && dec.rtype && wb_en && (rs2 == Rd);

`ifdef ALU_ISSUE_FWD_EN
    assign stall_haz = 1'b0;
    assign op_a      = haz_a ? Result : rf_a;
    assign op_b      = dec.rtype ? (haz_b ? Result : rf_b) : imm;
`else
    // Holding off one cycle lets the retire write land before the read.
    assign stall_haz = haz_a || haz_b;
    assign op_a      = rf_a;
    assign op_b      = dec.rtype ? rf_b : imm;
`endif

    assign instr_ready = (!ex_valid || ex_ready) && !stall_haz;
    assign accept      = instr_valid && instr_ready;

    regfile u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1),
        .ra2 (rs2),
        .rd1 (rf_a),
        .rd2 (rf_b),
        .we  (wb_en),
        .wa  (Rd),
        .wd  (Result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            illegal    <= 1'b0;
            A          <= '0;
            B          <= '0;
            ALUControl <= ALU_ADD;
            Rd         <= 5'd0;
        end else begin
            illegal <= accept && !dec.legal;
            if (accept) begin
                ex_valid <= dec.legal;
                if (dec.legal) begin
                    A          <= op_a;
                    B          <= op_b;
                    ALUControl <= dec.ctrl;
                    Rd         <= instr[11:7];
                end
            end else if (retire) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: ISA-level reference model with an expected queue of
// issued operations, checked every cycle, plus literal expectations.
`timescale 1ns/1ps
module tb_alu_issue;

`ifdef ALU_ISSUE_FWD_EN
    localparam int DEP_WAITS = 0;
`else
    localparam int DEP_WAITS = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        ex_ready = 1'b1;
    logic        instr_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUControl;
    logic [4:0]  Rd;
    logic        ex_valid;
    logic [31:0] Result;
    logic        illegal;

    alu_issue dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .A           (A),
        .B           (B),
        .ALUControl  (ALUControl),
        .Rd          (Rd),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .Result      (Result),
        .illegal     (illegal)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return a >> b[4:0];
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    always_comb Result = alu_f(A, B, ALUControl);

    // Returns {legal, ctrl}; rt flags an R-type (reads rs2).
    function automatic logic [3:0] ref_decode(input logic [31:0] ins, output logic rt);
        logic [16:0] key;
        key = {ins[6:0], ins[14:12], ins[31:25]};
        rt  = (ins[6:0] == 7'b0110011);
        casez (key)
            {7'b0110011, 3'b000, 7'b0000000}: return 4'b1000;
            {7'b0110011, 3'b000, 7'b0100000}: return 4'b1001;
            {7'b0110011, 3'b111, 7'b0000000}: return 4'b1010;
            {7'b0110011, 3'b110, 7'b0000000}: return 4'b1011;
            {7'b0110011, 3'b100, 7'b0000000}: return 4'b1100;
            {7'b0110011, 3'b001, 7'b0000000}: return 4'b1101;
            {7'b0110011, 3'b101, 7'b0000000}: return 4'b1110;
            {7'b0110011, 3'b010, 7'b0000000}: return 4'b1111;
            {7'b0010011, 3'b000, 7'b???????}: return 4'b1000;
            {7'b0010011, 3'b111, 7'b???????}: return 4'b1010;
            {7'b0010011, 3'b110, 7'b???????}: return 4'b1011;
            {7'b0010011, 3'b100, 7'b???????}: return 4'b1100;
            {7'b0010011, 3'b010, 7'b???????}: return 4'b1111;
            {7'b0010011, 3'b001, 7'b0000000}: return 4'b1101;
            {7'b0010011, 3'b101, 7'b0000000}: return 4'b1110;
            default:                          return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        lit_en;
        logic [31:0] lit_a;
        logic [31:0] lit_b;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
        logic [4:0]  rd;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic [W-1:0] exp_q[$];
    logic [31:0]  arch [32];
    int           n_checks = 0;
    int           n_fail = 0;
    int           ill_count = 0;
    logic         ill_pending = 1'b0;
    logic         rst_prev = 1'b1;
    logic         lit_en_n = 1'b0;
    logic [31:0]  lit_a_n = '0;
    logic [31:0]  lit_b_n = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    initial begin
        exp_t        f;
        exp_t        e;
        logic        ev;
        logic        rt;
        logic [3:0]  dc;
        logic        haz;
        logic        exp_rdy;
        logic [31:0] res;
        for (int i = 0; i < 32; i++) arch[i] = '0;
        forever begin
            @(negedge clk);
            ev = (exp_q.size() != 0);
            f  = '0;
            if (rst_prev) begin
                chk("rst_A", A, 32'd0);
                chk("rst_B", B, 32'd0);
                chk("rst_ctrl", {29'd0, ALUControl}, 32'd0);
                chk("rst_rd", {27'd0, Rd}, 32'd0);
            end
            if (illegal) ill_count++;
            chk("illegal", {31'd0, illegal}, {31'd0, ill_pending});
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, ev});
            if (ev) begin
                f = exp_t'(exp_q[0]);
                chk("ex_A", A, f.a);
                chk("ex_B", B, f.b);
                chk("ex_ctrl", {29'd0, ALUControl}, {29'd0, f.ctrl});
                chk("ex_rd", {27'd0, Rd}, {27'd0, f.rd});
                if (f.lit_en) begin
                    chk("lit_A", A, f.lit_a);
                    chk("lit_B", B, f.lit_b);
                end
            end
            dc  = ref_decode(instr, rt);
            haz = instr_valid && dc[3] && ev && ex_ready && (f.rd != 5'd0) &&
                  ((instr[19:15] == f.rd) || (rt && instr[24:20] == f.rd));
`ifdef ALU_ISSUE_FWD_EN
            exp_rdy = !ev || ex_ready;
`else
            exp_rdy = (!ev || ex_ready) && !haz;
`endif
            if (!rst) chk("instr_ready", {31'd0, instr_ready}, {31'd0, exp_rdy});
            ill_pending = 1'b0;
            if (rst) begin
                exp_q.delete();
                for (int i = 0; i < 32; i++) arch[i] = '0;
            end else begin
                if (ev && ex_ready) void'(exp_q.pop_front());
                if (instr_valid && instr_ready) begin
                    if (dc[3]) begin
                        e.a      = arch[instr[19:15]];
                        e.b      = rt ? arch[instr[24:20]] : {{20{instr[31]}}, instr[31:20]};
                        e.ctrl   = dc[2:0];
                        e.rd     = instr[11:7];
                        e.lit_en = lit_en_n;
                        e.lit_a  = lit_a_n;
                        e.lit_b  = lit_b_n;
                        res = alu_f(e.a, e.b, e.ctrl);
                        if (e.rd != 5'd0) arch[e.rd] = res;
                        exp_q.push_back(e);
                    end else begin
                        ill_pending = 1'b1;
                    end
                end
            end
            rst_prev = rst;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [31:0] ins, input logic le, input logic [31:0] la,
                         input logic [31:0] lb, output int waits);
        waits       = 0;
        instr       = ins;
        instr_valid = 1'b1;
        lit_en_n    = le;
        lit_a_n     = la;
        lit_b_n     = lb;
        forever begin
            @(negedge clk);
            if (instr_ready) break;
            waits++;
            if (waits > 20) begin
                n_checks++;
                n_fail++;
                $display("FAIL issue_timeout: instr_ready stayed 0, required 1 within 20 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        lit_en_n    = 1'b0;
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ADD x0, xr, x0 exposes x[r] on A without writing anything back.
    task automatic probe(input logic [4:0] r, input logic [31:0] val);
        int w;
        issue(r_type(7'b0000000, 5'd0, r, 3'b000, 5'd0), 1'b1, val, 32'd0, w);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w;
        int ill_base;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Baseline issue at full rate.
        issue(i_type(12'd124, 5'd0, 3'b000, 5'd1), 1'b1, 32'd0, 32'd124, w);
        chk("addi_x1_waits", w, 32'd0);
        issue(i_type(12'd73, 5'd0, 3'b000, 5'd2), 1'b1, 32'd0, 32'd73, w);
        chk("addi_x2_waits", w, 32'd0);
        // SUB x3,x1,x2 depends on the retiring ADDI x2.
        issue(r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3), 1'b1, 32'd124, 32'd73, w);
        chk("sub_dep_waits", w, DEP_WAITS);
        probe(5'd3, 32'd51);

        // Stall: AND x4,x1,x2 held with ex_ready low.
        idle(2);
        ex_ready = 1'b0;
        issue(r_type(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd4), 1'b1, 32'd124, 32'd73, w);
        idle(3);
        ex_ready = 1'b1;
        probe(5'd4, 32'd72);

        // Illegal: SRAI x5,x1,2 and SLTU x5,x1,x2.
        idle(2);
        ill_base = ill_count;
        issue(i_type(12'h402, 5'd1, 3'b101, 5'd5), 1'b0, 32'd0, 32'd0, w);
        issue(r_type(7'b0000000, 5'd2, 5'd1, 3'b011, 5'd5), 1'b0, 32'd0, 32'd0, w);
        idle(2);
        chk("illegal_pulses", ill_count - ill_base, 32'd2);
        probe(5'd5, 32'd0);

        // x0 handling.
        issue(i_type(12'd5, 5'd0, 3'b000, 5'd0), 1'b1, 32'd0, 32'd5, w);
        issue(r_type(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd6), 1'b1, 32'd0, 32'd0, w);
        chk("x0_no_hazard_waits", w, 32'd0);
        probe(5'd6, 32'd0);

        // Assorted operations, including a signed compare and shifts.
        issue(i_type(12'hFFB, 5'd0, 3'b000, 5'd7), 1'b1, 32'd0, 32'hFFFF_FFFB, w);
        issue(i_type(12'd3, 5'd7, 3'b010, 5'd8), 1'b1, 32'hFFFF_FFFB, 32'd3, w);
        issue(i_type(12'd4, 5'd1, 3'b001, 5'd9), 1'b1, 32'd124, 32'd4, w);
        issue(r_type(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd11), 1'b1, 32'd124, 32'd73, w);
        issue(r_type(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd12), 1'b1, 32'd124, 32'd73, w);
        issue(i_type(12'd3, 5'd9, 3'b101, 5'd13), 1'b1, 32'd1984, 32'd3, w);
        probe(5'd8, 32'd1);
        probe(5'd9, 32'd1984);
        probe(5'd11, 32'd53);
        probe(5'd12, 32'd125);
        probe(5'd13, 32'd248);

        // Reset while an operation is stalled in EX.
        idle(2);
        ex_ready = 1'b0;
        issue(i_type(12'd1, 5'd1, 3'b000, 5'd1), 1'b1, 32'd124, 32'd1, w);
        idle(1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ex_ready = 1'b1;
        for (int r = 1; r < 32; r++) probe(r[4:0], 32'd0);

        idle(3);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode/operand-issue stage directly upstream of the 32-bit ALU. Accepts RV32I register-register and register-immediate instructions over a valid/ready handshake and decodes each to the ALU's 3-bit `ALUControl`. Reads the 32x32 register file and presents registered `A`, `B`, `ALUControl` to the ALU. Writes the ALU's combinational `Result` back into the register file when the operation retires.

## Interface
- `XLEN`, 32, datapath width; fixed, only 32 supported.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  `instr` holds an instruction.
- `instr`  in  32  RV32I instruction word.
- `instr_ready`  out  1  stage accepts `instr` this cycle.
- `A`  out  32  ALU operand A, i.e. `x[rs1]`.
- `B`  out  32  ALU operand B: `x[rs2]` for R-type, or the sign-extended `imm[31:20]` for I-type.
- `ALUControl`  out  3  ALU operation select.
- `Rd`  out  5  destination register of the issued operation.
- `ex_valid`  out  1  `A`, `B`, `ALUControl` and `Rd` are valid.
- `ex_ready`  in  1  downstream consumes the operation this cycle.
- `Result`  in  32  ALU combinational result for the current `A`, `B`, `ALUControl`.
- `illegal`  out  1  one-cycle pulse: an accepted instruction was unsupported.

## Operation
- ALUControl encoding: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLL 101, SRL 110, SLT 111.
- OP (0110011), decoded by funct7/funct3:
  - 0000000/000 ADD; 0100000/000 SUB; 0000000/111 AND.
  - 0000000/110 OR; 0000000/100 XOR; 0000000/001 SLL.
  - 0000000/101 SRL; 0000000/010 SLT.
- OP-IMM (0010011), decoded by funct3:
  - 000 ADDI; 111 ANDI; 110 ORI; 100 XORI; 010 SLTI.
  - 001 SLLI, only with funct7 = 0000000.
  - 101 SRLI, only with funct7 = 0000000.
- Every other encoding is illegal, including SRA/SRAI, SLTU/SLTIU and all other opcodes.
- Handshake:
  - Accept when `instr_valid && instr_ready`.
  - `instr_ready = !ex_valid || ex_ready`.
- Retire: when `ex_valid && ex_ready`, write `Result` into `x[Rd]` unless `Rd == 0`.
- Register x0 always reads 0; writes to x0 are discarded.
- Legal accept: the EX register loads `A`, `B`, `ALUControl`, `Rd`; `ex_valid` is 1 the next cycle.
- Illegal accept: the instruction is consumed, `ex_valid` is 0 the next cycle and `illegal` is 1 for exactly one cycle; no writeback occurs.
- Stall: while `ex_valid && !ex_ready`, all EX outputs hold and `instr_ready` is 0.
- Reset:
  - `ex_valid`, `illegal`, `A`, `B`, `ALUControl`, `Rd` all go to 0.
  - All 31 architectural registers clear to 0.
  - `rst` dominates a simultaneous retire: no writeback and no accept in that cycle.

## Timing
- Issue latency: 1 cycle from accept to `ex_valid`.
- Throughput: 1 instruction per cycle when `ex_ready` is held high and there are no hazards.
- Register file:
  - Reads are combinational during the accept cycle.
  - The write lands at the retire edge.
  - A read in the same cycle as a write to the same register returns the old value unless bypassed.
- Hazard: a RAW hazard exists when an accepting instruction reads `rs1`, or reads `rs2` as an R-type, and that register equals the retiring `Rd`, with `Rd != 0`.

## Configuration
- `ALU_ISSUE_FWD_EN` defined:
  - On a hazard, the operand is taken from `Result`.
  - No stall; back-to-back dependent instructions issue at full rate.
- `ALU_ISSUE_FWD_EN` undefined:
  - On a hazard, `instr_ready` is forced to 0 for that cycle, so the retire completes first.
  - The instruction is accepted the following cycle, when `ex_valid` is 0 and the register file is updated.
  - Costs one bubble per dependent pair.

## Structure
- Shared package `alu_pkg` holds:
  - the `ALUControl` encoding constants;
  - the OP and OP-IMM opcode constants;
  - the funct7 constants 0000000 and 0100000.
- The ALU uses the same package.
- One sub-module, `regfile`:
  - 32x32, two combinational read ports, one synchronous write port.
  - x0 hardwired to zero; synchronous clear on `rst`.

## Test plan
- Baseline, `ex_ready` held at 1:
  - Stimulus: reset, then ADDI x1,x0,124 and ADDI x2,x0,73 on consecutive cycles.
  - Response: `ex_valid` with A=0/B=124 ALUControl 000, then A=0/B=73; x1=124, x2=73.
- Dependent R-type:
  - Stimulus: SUB x3,x1,x2 immediately after ADDI x2.
  - With FWD: `instr_ready` stays 1; A=124, B=73, ALUControl 001; x3=51.
  - Without FWD: exactly one `instr_ready`=0 cycle, then the same values.
- Stall:
  - Stimulus: hold `ex_ready`=0 for 3 cycles during AND x4,x1,x2.
  - Response: outputs stable, `instr_ready`=0; single writeback x4=72 when `ex_ready` rises.
- Illegal:
  - Stimulus: SRAI x5,x1,2, then SLTU x5,x1,x2.
  - Response: two `illegal` pulses, `ex_valid` stays 0, x5 remains 0.
- x0 handling:
  - Stimulus: ADDI x0,x0,5, then ADD x6,x0,x0.
  - Response: the second instruction issues A=0, B=0; x6=0.
- Reset mid-stall:
  - Stimulus: assert `rst` while `ex_valid=1, ex_ready=0`.
  - Response: next cycle `ex_valid`=0, all outputs 0, no writeback, x1..x31 read 0.
